// File: rtl/obi_mgr_pkg.sv
// Shared types and helpers for the OBI manager arbiter.
package obi_mgr_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } arb_state_e;

  // Index width for a controller count; a single controller still gets one bit.
  function automatic int unsigned idx_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

  // Byte-enable fill for a data width of up to 64 bits; callers slice the low DATA_WIDTH/8 bits.
  function automatic logic [7:0] be_all_ones(input int unsigned dw);
    logic [7:0] be;
    be = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      if (i < dw / 8) be[i] = 1'b1;
    end
    return be;
  endfunction

endpackage

// File: rtl/obi_rr_picker.sv
// Combinational round-robin pick: first set req bit scanning from rr_ptr_i upward with wrap.
// Ports: req_i request vector, rr_ptr_i scan start; gnt_o one-hot winner, idx_o winner index,
// any_o set when any request is present.
module obi_rr_picker
  import obi_mgr_pkg::*;
#(
  parameter int unsigned NUM_REQ = 4,
  parameter int unsigned IDX_W   = idx_w(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0]   idx_o,
  output logic               any_o
);

  int unsigned      cand;
  logic [IDX_W-1:0] cand_idx;

  always_comb begin
    gnt_o    = '0;
    idx_o    = '0;
    any_o    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      cand = 32'(rr_ptr_i) + i;
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      cand_idx = IDX_W'(cand);
      if (!any_o && req_i[cand_idx]) begin
        any_o           = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/obi_mgr_arbiter.sv
// Round-robin arbiter sharing one OBI manager port among NUM_REQ controllers, one
// transaction outstanding at a time.
// Ports: controller side req_i/we_i/addr_i/wdata_i in, gnt_o/rvalid_o/rdata_o/err_o out;
// status err_cnt_o (saturating error count) and proto_err_o (sticky stray rvalid);
// OBI side obi_req_o/obi_addr_o/obi_we_o/obi_be_o/obi_wdata_o/obi_rready_o out,
// obi_gnt_i/obi_rvalid_i/obi_rdata_i/obi_err_i in.
module obi_mgr_arbiter
  import obi_mgr_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic [NUM_REQ-1:0]              req_i,
  input  logic [NUM_REQ-1:0]              we_i,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]   addr_i,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]   wdata_i,
  output logic [NUM_REQ-1:0]              gnt_o,
  output logic [NUM_REQ-1:0]              rvalid_o,
  output logic [DATA_WIDTH-1:0]           rdata_o,
  output logic                            err_o,
  output logic [7:0]                      err_cnt_o,
  output logic                            proto_err_o,
  output logic                            obi_req_o,
  input  logic                            obi_gnt_i,
  output logic [ADDR_WIDTH-1:0]           obi_addr_o,
  output logic                            obi_we_o,
  output logic [DATA_WIDTH/8-1:0]         obi_be_o,
  output logic [DATA_WIDTH-1:0]           obi_wdata_o,
  input  logic                            obi_rvalid_i,
  output logic                            obi_rready_o,
  input  logic [DATA_WIDTH-1:0]           obi_rdata_i,
  input  logic                            obi_err_i
);

  localparam int unsigned IDX_W  = idx_w(NUM_REQ);
  localparam logic [7:0]  BE_ALL = be_all_ones(DATA_WIDTH);

  arb_state_e              state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        owner_q, owner_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    we_q, we_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [7:0]              err_cnt_q, err_cnt_d;
  logic                    proto_err_q, proto_err_d;

  logic [NUM_REQ-1:0]      pick_gnt;
  logic [IDX_W-1:0]        pick_idx;
  logic                    pick_any;

  logic [ADDR_WIDTH-1:0]   addr_arr  [NUM_REQ];
  logic [DATA_WIDTH-1:0]   wdata_arr [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign addr_arr[k]  = addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    assign wdata_arr[k] = wdata_i[k*DATA_WIDTH +: DATA_WIDTH];
  end

  obi_rr_picker #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_picker (
    .req_i    (req_i),
    .rr_ptr_i (rr_ptr_q),
    .gnt_o    (pick_gnt),
    .idx_o    (pick_idx),
    .any_o    (pick_any)
  );

  always_comb begin
    state_d      = state_q;
    rr_ptr_d     = rr_ptr_q;
    owner_d      = owner_q;
    addr_d       = addr_q;
    we_d         = we_q;
    wdata_d      = wdata_q;
    err_cnt_d    = err_cnt_q;
    proto_err_d  = proto_err_q;
    gnt_o        = '0;
    rvalid_o     = '0;
    rdata_o      = '0;
    err_o        = 1'b0;
    obi_req_o    = 1'b0;
    obi_rready_o = 1'b0;

    // A response arriving while none is outstanding is dropped and flagged.
    if (obi_rvalid_i && (state_q != RSP)) proto_err_d = 1'b1;

    unique case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_o   = pick_gnt;
          addr_d  = addr_arr[pick_idx];
          we_d    = we_i[pick_idx];
          wdata_d = wdata_arr[pick_idx];
          owner_d = pick_idx;
          state_d = REQ;
        end
      end
      REQ: begin
        obi_req_o = 1'b1;
        if (obi_gnt_i) state_d = RSP;
      end
      RSP: begin
        obi_rready_o = 1'b1;
        if (obi_rvalid_i) begin
          rvalid_o[owner_q] = 1'b1;
          rdata_o           = obi_rdata_i;
          err_o             = obi_err_i;
          rr_ptr_d          = (owner_q == IDX_W'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
          state_d           = IDLE;
          if (obi_err_i && (err_cnt_q != '1)) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      owner_q     <= '0;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      err_cnt_q   <= '0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      owner_q     <= owner_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      err_cnt_q   <= err_cnt_d;
      proto_err_q <= proto_err_d;
    end
  end

  assign obi_addr_o  = addr_q;
  assign obi_we_o    = we_q;
  assign obi_wdata_o = wdata_q;
  assign obi_be_o    = BE_ALL[DATA_WIDTH/8-1:0];
  assign err_cnt_o   = err_cnt_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_obi_mgr_arbiter.sv
module tb_obi_mgr_arbiter;

  logic        clk = 1'b0;
  logic        reset_ni = 1'b0;
  logic [3:0]  req = '0;
  logic [3:0]  we = '0;
  logic [31:0] addr [4];
  logic [31:0] wdata [4];
  logic [127:0] addr_p, wdata_p;

  logic [3:0]  gnt_o, rvalid_o;
  logic [31:0] rdata_o;
  logic        err_o;
  logic [7:0]  err_cnt_o;
  logic        proto_err_o;
  logic        obi_req_o;
  logic        obi_gnt = 1'b0;
  logic [31:0] obi_addr_o;
  logic        obi_we_o;
  logic [3:0]  obi_be_o;
  logic [31:0] obi_wdata_o;
  logic        obi_rvalid = 1'b0;
  logic        obi_rready_o;
  logic [31:0] obi_rdata = '0;
  logic        obi_err = 1'b0;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int m_rr = 0;
  int m_errcnt = 0;

  logic [3:0]  obs_gnt, obs_rvalid;
  logic [31:0] obs_addr, obs_wdata, obs_rdata;
  logic        obs_we, obs_err, obs_stable;
  int          obs_gcyc;

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  always_comb begin
    for (int k = 0; k < 4; k++) begin
      addr_p[k*32 +: 32]  = addr[k];
      wdata_p[k*32 +: 32] = wdata[k];
    end
  end

  obi_mgr_arbiter #(
    .NUM_REQ    (4),
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32)
  ) dut (
    .clk_i        (clk),
    .reset_ni     (reset_ni),
    .req_i        (req),
    .we_i         (we),
    .addr_i       (addr_p),
    .wdata_i      (wdata_p),
    .gnt_o        (gnt_o),
    .rvalid_o     (rvalid_o),
    .rdata_o      (rdata_o),
    .err_o        (err_o),
    .err_cnt_o    (err_cnt_o),
    .proto_err_o  (proto_err_o),
    .obi_req_o    (obi_req_o),
    .obi_gnt_i    (obi_gnt),
    .obi_addr_o   (obi_addr_o),
    .obi_we_o     (obi_we_o),
    .obi_be_o     (obi_be_o),
    .obi_wdata_o  (obi_wdata_o),
    .obi_rvalid_i (obi_rvalid),
    .obi_rready_o (obi_rready_o),
    .obi_rdata_i  (obi_rdata),
    .obi_err_i    (obi_err)
  );

  // Reference: first requester at or after the pointer, circularly.
  function automatic int model_pick(input logic [3:0] r, input int ptr);
    for (int i = 0; i < 4; i++) begin
      int c;
      c = (ptr + i) % 4;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [3:0] onehot(input int w);
    logic [3:0] v;
    v = '0;
    if (w >= 0) v[w] = 1'b1;
    return v;
  endfunction

  task automatic idle_inputs();
    req = '0; we = '0; obi_gnt = 1'b0; obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
    for (int k = 0; k < 4; k++) begin addr[k] = '0; wdata[k] = '0; end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    reset_ni = 1'b1;
    m_rr = 0;
    m_errcnt = 0;
  endtask

  // Pure driver: runs one transaction from the current IDLE cycle and records what the DUT showed.
  task automatic drive_txn(input int gw, input int rw, input logic [31:0] rd, input logic er);
    #1;
    obs_gnt  = gnt_o;
    obs_gcyc = cyc;
    @(negedge clk);
    req = req & ~obs_gnt;
    obs_stable = 1'b1;
    for (int j = 0; j <= gw; j++) begin
      obi_gnt = (j == gw);
      #1;
      if (j == 0) begin
        obs_addr = obi_addr_o; obs_we = obi_we_o; obs_wdata = obi_wdata_o;
      end
      if (obi_req_o !== 1'b1 || obi_addr_o !== obs_addr || obi_we_o !== obs_we ||
          obi_wdata_o !== obs_wdata || gnt_o !== 4'b0000)
        obs_stable = 1'b0;
      @(negedge clk);
    end
    obi_gnt = 1'b0;
    for (int j = 0; j <= rw; j++) begin
      obi_rvalid = (j == rw);
      obi_rdata  = (j == rw) ? rd : '0;
      obi_err    = (j == rw) ? er : 1'b0;
      #1;
      if (j == rw) begin
        obs_rvalid = rvalid_o; obs_rdata = rdata_o; obs_err = err_o;
      end else if (obi_rready_o !== 1'b1 || rvalid_o !== 4'b0000) begin
        obs_stable = 1'b0;
      end
      @(negedge clk);
    end
    obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_ni = 1'b0;
    idle_inputs();
    #1;
    total++; if ({gnt_o, rvalid_o} !== 8'h00) begin bad++; $display("FAIL rst_gnt_rvalid got=%h exp=00", {gnt_o, rvalid_o}); end
    total++; if ({rdata_o, err_o} !== 33'h0) begin bad++; $display("FAIL rst_rdata_err got=%h exp=0", {rdata_o, err_o}); end
    total++; if (err_cnt_o !== 8'd0) begin bad++; $display("FAIL rst_err_cnt got=%0d exp=0", err_cnt_o); end
    total++; if (proto_err_o !== 1'b0) begin bad++; $display("FAIL rst_proto got=%b exp=0", proto_err_o); end
    total++; if ({obi_req_o, obi_rready_o} !== 2'b00) begin bad++; $display("FAIL rst_obi_ctl got=%b exp=00", {obi_req_o, obi_rready_o}); end
    total++; if ({obi_addr_o, obi_we_o, obi_wdata_o} !== 65'h0) begin bad++; $display("FAIL rst_obi_a got=%h exp=0", {obi_addr_o, obi_we_o, obi_wdata_o}); end
    total++; if (obi_be_o !== 4'hF) begin bad++; $display("FAIL rst_be got=%h exp=f", obi_be_o); end
    @(negedge clk);
    reset_ni = 1'b1;
    m_rr = 0; m_errcnt = 0;
    @(negedge clk);
    total++; if ({gnt_o, obi_req_o, obi_rready_o} !== 6'h0) begin bad++; $display("FAIL post_rst_idle got=%h exp=0", {gnt_o, obi_req_o, obi_rready_o}); end
  endtask

  task automatic test_single_read();
    do_reset();
    req = 4'b0100; we = 4'b0000; addr[2] = 32'h1000_0010; wdata[2] = 32'h1234_5678;
    drive_txn(2, 0, 32'hDEAD_BEEF, 1'b0);
    total++; if (obs_gnt !== 4'b0100) begin bad++; $display("FAIL single_gnt got=%b exp=0100", obs_gnt); end
    total++; if (obs_addr !== 32'h1000_0010 || obs_we !== 1'b0) begin bad++; $display("FAIL single_addr got=%h/%b exp=10000010/0", obs_addr, obs_we); end
    total++; if (obs_stable !== 1'b1) begin bad++; $display("FAIL single_a_stable got=%b exp=1", obs_stable); end
    total++; if (obs_rvalid !== 4'b0100 || obs_rdata !== 32'hDEAD_BEEF) begin bad++; $display("FAIL single_rsp got=%b/%h exp=0100/deadbeef", obs_rvalid, obs_rdata); end
    m_rr = 3;
    req = 4'b1111;
    for (int k = 0; k < 4; k++) begin addr[k] = 32'h100 * k; wdata[k] = '0; end
    drive_txn(0, 0, 32'h0, 1'b0);
    total++; if (obs_gnt !== onehot(model_pick(4'b1111, m_rr))) begin bad++; $display("FAIL single_ptr3 got=%b exp=%b", obs_gnt, onehot(model_pick(4'b1111, m_rr))); end
    m_rr = (model_pick(4'b1111, m_rr) + 1) % 4;
  endtask

  task automatic test_contention();
    int prev;
    int w;
    do_reset();
    for (int k = 0; k < 4; k++) begin addr[k] = 32'hA000_0000 + k; wdata[k] = 32'h5000 + k; end
    prev = -1;
    for (int t = 0; t < 5; t++) begin
      req = 4'b1111;
      w = model_pick(req, m_rr);
      drive_txn(0, 0, 32'hC0DE_0000 + t, 1'b0);
      total++; if (obs_gnt !== onehot(w)) begin bad++; $display("FAIL cont_gnt t=%0d got=%b exp=%b", t, obs_gnt, onehot(w)); end
      total++; if (obs_rvalid !== onehot(w) || obs_addr !== addr[w]) begin bad++; $display("FAIL cont_rsp t=%0d got=%b/%h exp=%b/%h", t, obs_rvalid, obs_addr, onehot(w), addr[w]); end
      if (prev >= 0) begin
        total++; if (obs_gcyc - prev !== 3) begin bad++; $display("FAIL cont_spacing t=%0d got=%0d exp=3", t, obs_gcyc - prev); end
      end
      prev = obs_gcyc;
      m_rr = (w + 1) % 4;
    end
    req = '0;
  endtask

  task automatic test_wrap();
    int w;
    do_reset();
    for (int k = 0; k < 4; k++) begin addr[k] = 32'hB000_0000 + k; wdata[k] = '0; end
    req = 4'b0100;
    drive_txn(0, 0, 32'h0, 1'b0);
    m_rr = 3;
    req = 4'b1001;
    w = model_pick(req, m_rr);
    drive_txn(1, 1, 32'h0, 1'b0);
    total++; if (obs_gnt !== onehot(w)) begin bad++; $display("FAIL wrap_first got=%b exp=%b", obs_gnt, onehot(w)); end
    m_rr = (w + 1) % 4;
    w = model_pick(req, m_rr);
    drive_txn(0, 0, 32'h0, 1'b0);
    total++; if (obs_gnt !== onehot(w)) begin bad++; $display("FAIL wrap_second got=%b exp=%b", obs_gnt, onehot(w)); end
    m_rr = (w + 1) % 4;
    req = 4'b1111;
    w = model_pick(req, m_rr);
    drive_txn(0, 0, 32'h0, 1'b0);
    total++; if (obs_gnt !== onehot(w)) begin bad++; $display("FAIL wrap_ptr1 got=%b exp=%b", obs_gnt, onehot(w)); end
    m_rr = (w + 1) % 4;
    req = '0;
  endtask

  task automatic test_error_path();
    int k;
    do_reset();
    req = 4'b0001; we = 4'b0001; addr[0] = 32'h20; wdata[0] = 32'hA5A5_A5A5;
    drive_txn(1, 1, 32'h0, 1'b1);
    m_errcnt = 1;
    total++; if (obs_addr !== 32'h20 || obs_we !== 1'b1 || obs_wdata !== 32'hA5A5_A5A5) begin bad++; $display("FAIL err_write got=%h/%b/%h exp=20/1/a5a5a5a5", obs_addr, obs_we, obs_wdata); end
    total++; if (obs_rvalid !== 4'b0001 || obs_err !== 1'b1) begin bad++; $display("FAIL err_rsp got=%b/%b exp=0001/1", obs_rvalid, obs_err); end
    total++; if (err_cnt_o !== 8'(m_errcnt)) begin bad++; $display("FAIL err_cnt1 got=%0d exp=%0d", err_cnt_o, m_errcnt); end
    for (int t = 0; t < 300; t++) begin
      k = $urandom_range(0, 3);
      req = onehot(k); we = 4'b0000;
      drive_txn(0, 0, $urandom, 1'b1);
      if (m_errcnt < 255) m_errcnt++;
      total++; if (err_cnt_o !== 8'(m_errcnt)) begin bad++; $display("FAIL err_cnt_sat t=%0d got=%0d exp=%0d", t, err_cnt_o, m_errcnt); end
    end
    req = 4'b0010;
    drive_txn(0, 0, 32'h0, 1'b0);
    total++; if (err_cnt_o !== 8'd255 || obs_err !== 1'b0) begin bad++; $display("FAIL err_cnt_ok_rsp got=%0d/%b exp=255/0", err_cnt_o, obs_err); end
    req = '0;
  endtask

  task automatic test_spurious();
    do_reset();
    obi_rvalid = 1'b1; obi_rdata = 32'hFFFF_FFFF; obi_err = 1'b1;
    #1;
    total++; if ({rvalid_o, rdata_o, err_o} !== 37'h0) begin bad++; $display("FAIL spur_pass got=%h exp=0", {rvalid_o, rdata_o, err_o}); end
    @(negedge clk);
    obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL spur_proto got=%b exp=1", proto_err_o); end
    total++; if (err_cnt_o !== 8'd0) begin bad++; $display("FAIL spur_errcnt got=%0d exp=0", err_cnt_o); end
    req = 4'b0001; addr[0] = 32'h44;
    drive_txn(0, 0, 32'h1, 1'b0);
    total++; if (proto_err_o !== 1'b1 || obs_rvalid !== 4'b0001) begin bad++; $display("FAIL spur_sticky got=%b/%b exp=1/0001", proto_err_o, obs_rvalid); end
    req = '0;
  endtask

  task automatic test_reset_in_rsp();
    do_reset();
    req = 4'b0100; addr[2] = 32'h300;
    drive_txn(0, 0, 32'h0, 1'b0);
    req = 4'b0010; addr[1] = 32'h200; wdata[1] = 32'h77;
    #1;
    total++; if (gnt_o !== 4'b0010) begin bad++; $display("FAIL rrsp_gnt got=%b exp=0010", gnt_o); end
    @(negedge clk);
    req = '0; obi_gnt = 1'b1;
    @(negedge clk);
    obi_gnt = 1'b0;
    #1;
    total++; if (obi_rready_o !== 1'b1) begin bad++; $display("FAIL rrsp_in_rsp got=%b exp=1", obi_rready_o); end
    reset_ni = 1'b0;
    #1;
    total++; if ({gnt_o, rvalid_o, rdata_o, err_o, err_cnt_o, proto_err_o, obi_req_o, obi_rready_o} !== 53'h0) begin bad++; $display("FAIL rrsp_outs got=%h exp=0", {gnt_o, rvalid_o, rdata_o, err_o, err_cnt_o, proto_err_o, obi_req_o, obi_rready_o}); end
    total++; if ({obi_addr_o, obi_we_o, obi_wdata_o} !== 65'h0 || obi_be_o !== 4'hF) begin bad++; $display("FAIL rrsp_obi got=%h/%h exp=0/f", {obi_addr_o, obi_we_o, obi_wdata_o}, obi_be_o); end
    @(negedge clk);
    reset_ni = 1'b1;
    m_rr = 0; m_errcnt = 0;
    obi_rvalid = 1'b1; obi_rdata = 32'h1111_2222;
    #1;
    total++; if (rvalid_o !== 4'b0000 || rdata_o !== 32'h0) begin bad++; $display("FAIL rrsp_late_rsp got=%b/%h exp=0000/0", rvalid_o, rdata_o); end
    @(negedge clk);
    obi_rvalid = 1'b0; obi_rdata = '0;
    total++; if (proto_err_o !== 1'b1) begin bad++; $display("FAIL rrsp_proto got=%b exp=1", proto_err_o); end
    req = 4'b1111;
    drive_txn(0, 0, 32'h0, 1'b0);
    total++; if (obs_gnt !== onehot(model_pick(4'b1111, m_rr))) begin bad++; $display("FAIL rrsp_ptr0 got=%b exp=%b", obs_gnt, onehot(model_pick(4'b1111, m_rr))); end
    req = '0;
  endtask

  task automatic test_random();
    int w, gw, rw;
    logic [31:0] ea, ed, rd;
    logic ew, er;
    do_reset();
    for (int t = 0; t < 150; t++) begin
      for (int k = 0; k < 4; k++) begin
        if (!req[k] && ($urandom_range(0, 1) == 1)) begin
          req[k] = 1'b1; we[k] = $urandom_range(0, 1); addr[k] = $urandom; wdata[k] = $urandom;
        end
      end
      if (req == 4'b0000) begin
        w = $urandom_range(0, 3);
        req[w] = 1'b1; we[w] = $urandom_range(0, 1); addr[w] = $urandom; wdata[w] = $urandom;
      end
      w = model_pick(req, m_rr);
      ea = addr[w]; ew = we[w]; ed = wdata[w];
      #1;
      total++; if (gnt_o !== onehot(w)) begin bad++; $display("FAIL rnd_gnt t=%0d got=%b exp=%b", t, gnt_o, onehot(w)); end
      @(negedge clk);
      req[w] = 1'b0;
      gw = $urandom_range(0, 3);
      for (int j = 0; j <= gw; j++) begin
        obi_gnt = (j == gw);
        #1;
        total++;
        if ({obi_req_o, obi_addr_o, obi_we_o, obi_wdata_o, gnt_o} !== {1'b1, ea, ew, ed, 4'b0000}) begin
          bad++; $display("FAIL rnd_a t=%0d got=%b/%h/%b/%h exp=1/%h/%b/%h", t, obi_req_o, obi_addr_o, obi_we_o, obi_wdata_o, ea, ew, ed);
        end
        @(negedge clk);
      end
      obi_gnt = 1'b0;
      rw = $urandom_range(0, 3);
      for (int j = 0; j < rw; j++) begin
        #1;
        total++; if ({obi_rready_o, rvalid_o, obi_req_o} !== 6'b100000) begin bad++; $display("FAIL rnd_wait t=%0d got=%b/%b/%b exp=1/0000/0", t, obi_rready_o, rvalid_o, obi_req_o); end
        @(negedge clk);
      end
      rd = $urandom; er = ($urandom_range(0, 3) == 0);
      obi_rvalid = 1'b1; obi_rdata = rd; obi_err = er;
      #1;
      total++; if ({rvalid_o, rdata_o, err_o} !== {onehot(w), rd, er}) begin bad++; $display("FAIL rnd_rsp t=%0d got=%b/%h/%b exp=%b/%h/%b", t, rvalid_o, rdata_o, err_o, onehot(w), rd, er); end
      m_rr = (w + 1) % 4;
      if (er && m_errcnt < 255) m_errcnt++;
      @(negedge clk);
      obi_rvalid = 1'b0; obi_rdata = '0; obi_err = 1'b0;
      total++; if (err_cnt_o !== 8'(m_errcnt) || proto_err_o !== 1'b0) begin bad++; $display("FAIL rnd_status t=%0d got=%0d/%b exp=%0d/0", t, err_cnt_o, proto_err_o, m_errcnt); end
    end
    req = '0;
  endtask

  initial begin
    idle_inputs();
    test_reset();
    test_single_read();
    test_contention();
    test_wrap();
    test_error_path();
    test_spurious();
    test_reset_in_rsp();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/obi_mgr_arbiter.md
Name: obi_mgr_arbiter

Overview:
Round-robin arbiter that shares one OBI manager port among NUM_REQ local controllers. It accepts one controller request at a time and registers the winner's address, write enable and write data. It drives the OBI A channel until the subordinate grants, then waits for the R response and routes it back to the owning controller. It sits between several controller front-ends and a single OBI subordinate. Only one transaction is outstanding at any time.

Parameters:
NUM_REQ, 4, number of controller ports (1..16)
ADDR_WIDTH, 32, OBI address width (32 or 64)
DATA_WIDTH, 32, OBI data width (32 or 64)

Ports:
clk_i  in  1  clock
reset_ni  in  1  reset
req_i  in  NUM_REQ  per-controller request; level, held until matching gnt_o
we_i  in  NUM_REQ  per-controller write enable
addr_i  in  NUM_REQ*ADDR_WIDTH  packed addresses; controller k in slice k
wdata_i  in  NUM_REQ*DATA_WIDTH  packed write data; controller k in slice k
gnt_o  out  NUM_REQ  one-hot, one-cycle acceptance pulse
rvalid_o  out  NUM_REQ  one-hot, one-cycle response pulse to owner
rdata_o  out  DATA_WIDTH  response data, valid with rvalid_o
err_o  out  1  response error, valid with rvalid_o
err_cnt_o  out  8  saturating count of responses with obi_err_i=1
proto_err_o  out  1  sticky flag: obi_rvalid_i seen outside RSP state
obi_req_o  out  1  OBI A-channel request
obi_gnt_i  in  1  OBI grant
obi_addr_o  out  ADDR_WIDTH  OBI address
obi_we_o  out  1  OBI write enable
obi_be_o  out  DATA_WIDTH/8  byte enables, tied to all ones
obi_wdata_o  out  DATA_WIDTH  OBI write data
obi_rvalid_i  in  1  OBI response valid
obi_rready_o  out  1  OBI response ready
obi_rdata_i  in  DATA_WIDTH  OBI read data
obi_err_i  in  1  OBI error

Behaviour:
- Reset (reset_ni asynchronous, active-low):
  - state=IDLE, rr_ptr=0, owner=0.
  - addr/we/wdata registers cleared.
  - err_cnt_o=0, proto_err_o=0.
  - All outputs 0, except obi_be_o, which is all ones.
- A reset mid-transaction abandons that transaction. No response is delivered afterwards.
- FSM states: IDLE, REQ, RSP.
- IDLE:
  - Winner is the first set req_i bit scanning rr_ptr, rr_ptr+1, … with wrap from NUM_REQ-1 to 0.
  - If any req_i is set, gnt_o[winner]=1 combinationally in the same cycle.
  - At the clock edge: capture winner's addr, we and wdata; owner<=winner; state<=REQ.
  - If no req_i is set, stay in IDLE.
- REQ:
  - obi_req_o=1 with the captured addr/we/wdata, stable until grant.
  - On obi_gnt_i=1, go to RSP; otherwise stay.
  - gnt_o=0.
- RSP:
  - obi_rready_o=1.
  - On obi_rvalid_i=1 (combinational pass-through): rvalid_o[owner]=1, rdata_o=obi_rdata_i, err_o=obi_err_i.
  - Same edge: rr_ptr<=(owner+1) mod NUM_REQ; state<=IDLE.
  - If obi_err_i=1, err_cnt_o increments, saturating at 255.
- Outside RSP: obi_rready_o=0, rvalid_o=0, rdata_o=0, err_o=0.
- obi_rvalid_i=1 in IDLE or REQ (including the grant cycle) is ignored and sets proto_err_o.
- Latency and throughput:
  - Minimum 3 cycles per transaction: IDLE→REQ→RSP.
  - Back-to-back requests from the same controller are accepted in the IDLE cycle after rvalid_o.
- Fairness: a controller waits at most NUM_REQ-1 other transactions.
- Controller obligations: req_i, we_i, addr_i and wdata_i are held stable while req_i is set and gnt_o is low. A drop before grant is allowed and simply withdraws the request.
- NUM_REQ=1: winner is always 0; rr_ptr stays 0.
- Write responses: rdata_o is passed through but carries no meaning.

Decomposition:
- Package obi_mgr_pkg:
  - state enum arb_state_e {IDLE, REQ, RSP}.
  - Localparam helper IDX_W=(NUM_REQ>1)?$clog2(NUM_REQ):1.
  - BE_ALL_ONES constant function of DATA_WIDTH.
- Sub-module obi_rr_picker:
  - Combinational round-robin pick.
  - Inputs: req vector, rr_ptr.
  - Outputs: one-hot grant, binary index, any_req.
  - Unit-tested separately.
- The rr_ptr register lives in obi_mgr_arbiter.

Test Plan:
- Single read, NUM_REQ=4: req_i=4'b0100, we=0, addr2=0x1000_0010; gnt_i after 2 cycles; rvalid with rdata=0xDEADBEEF → gnt_o=0100 in cycle 0; obi_addr_o=0x1000_0010 from cycle 1; rvalid_o=0100, rdata_o=0xDEADBEEF; rr_ptr=3.
- Contention, all four req_i held, gnt_i and rvalid_i immediate → grant order 0,1,2,3,0 with one transaction every 3 cycles.
- Wrap: rr_ptr=3, req_i=4'b1001 → controller 3 first, then 0; rr_ptr wraps to 0, then 1.
- Error path: write, addr=0x20, wdata=0xA5A5A5A5, response obi_err_i=1 → err_o=1 with rvalid_o; err_cnt_o=1; after 300 error responses err_cnt_o=255.
- Spurious rvalid: obi_rvalid_i=1 in IDLE → no rvalid_o; proto_err_o=1 and stays 1 until reset.
- Reset in RSP: deassert reset_ni for 1 cycle before rvalid → all outputs 0, state IDLE, rr_ptr=0; a later rvalid yields no rvalid_o and sets proto_err_o.
